// File: rtl/matmul_sequencer.sv
// matmul_sequencer: central phase sequencer for the matrix-multiply accelerator.
// It walks LOAD -> MAC/WRITE -> (POST) -> DONE and drives the address/enable
// lines of the X buffer, coefficient ROM, MAC unit and result RAM.
// Optional avg/max post-processing phase: define MATMUL_SEQ_AVGMAX_EN.
// Every output is a register, so each one reflects the decision taken on the
// previous rising edge of clk.

module matmul_sequencer #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int INNER = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_in,
    input  logic                            valid_input,
    output logic                            x_load_en,
    output logic [$clog2(ROWS*INNER)-1:0]   x_addr,
    output logic [$clog2(COLS*INNER)-1:0]   rom_addr,
    output logic                            mac_en,
    output logic                            mac_clr,
    output logic                            ram_we,
    output logic                            ram_re,
    output logic [$clog2(ROWS*COLS)-1:0]    ram_addr,
    output logic                            post_en,
    output logic                            busy,
    output logic                            finish
);

    localparam int XW  = $clog2(ROWS*INNER);
    localparam int RW  = $clog2(COLS*INNER);
    localparam int AW  = $clog2(ROWS*COLS);
    localparam int RBW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int CBW = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int KBW = (INNER > 1) ? $clog2(INNER) : 1;

    localparam logic [XW-1:0]  X_LAST = XW'(ROWS*INNER - 1);
    localparam logic [RBW-1:0] R_LAST = RBW'(ROWS - 1);
    localparam logic [CBW-1:0] C_LAST = CBW'(COLS - 1);
    localparam logic [KBW-1:0] K_LAST = KBW'(INNER - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE,
`ifdef MATMUL_SEQ_AVGMAX_EN
        POST,
`endif
        DONE
    } state_t;

    state_t         state;
    logic [XW-1:0]  load_cnt;
    logic [RBW-1:0] r;
    logic [CBW-1:0] c;
    logic [KBW-1:0] k;

`ifdef MATMUL_SEQ_AVGMAX_EN
    localparam logic [AW-1:0] J_LAST = AW'(ROWS*COLS - 1);

    logic          ram_re_q;
    logic          post_en_q;
    logic          post_flush;
    logic [AW-1:0] j;

    assign ram_re  = ram_re_q;
    assign post_en = post_en_q;
`else
    assign ram_re  = 1'b0;
    assign post_en = 1'b0;
`endif

    // Phase sequencer: state, loop counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            r         <= '0;
            c         <= '0;
            k         <= '0;
            x_load_en <= 1'b0;
            x_addr    <= '0;
            rom_addr  <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
`ifdef MATMUL_SEQ_AVGMAX_EN
            ram_re_q   <= 1'b0;
            post_en_q  <= 1'b0;
            post_flush <= 1'b0;
            j          <= '0;
`endif
        end else begin
            x_load_en <= 1'b0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            ram_we    <= 1'b0;
            finish    <= 1'b0;
            busy      <= 1'b1;
`ifdef MATMUL_SEQ_AVGMAX_EN
            ram_re_q  <= 1'b0;
            post_en_q <= ram_re_q;
`endif
            case (state)
                IDLE: begin
                    busy     <= start_in;
                    load_cnt <= '0;
                    if (start_in) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (valid_input) begin
                        x_load_en <= 1'b1;
                        x_addr    <= load_cnt;
                        if (load_cnt == X_LAST) begin
                            load_cnt <= '0;
                            r        <= '0;
                            c        <= '0;
                            k        <= '0;
                            state    <= MAC;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end

                MAC: begin
                    mac_en   <= 1'b1;
                    mac_clr  <= (k == '0);
                    x_addr   <= XW'(r) * XW'(INNER) + XW'(k);
                    rom_addr <= RW'(c) * RW'(INNER) + RW'(k);
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= WRITE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                WRITE: begin
                    ram_we   <= 1'b1;
                    ram_addr <= AW'(r) * AW'(COLS) + AW'(c);
                    if (c == C_LAST) begin
                        c <= '0;
                        if (r == R_LAST) begin
                            r <= '0;
`ifdef MATMUL_SEQ_AVGMAX_EN
                            state <= POST;
`else
                            state <= DONE;
`endif
                        end else begin
                            r     <= r + 1'b1;
                            state <= MAC;
                        end
                    end else begin
                        c     <= c + 1'b1;
                        state <= MAC;
                    end
                end

`ifdef MATMUL_SEQ_AVGMAX_EN
                POST: begin
                    if (!post_flush) begin
                        ram_re_q <= 1'b1;
                        ram_addr <= j;
                        if (j == J_LAST) begin
                            j          <= '0;
                            post_flush <= 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        post_flush <= 1'b0;
                        state      <= DONE;
                    end
                end
`endif

                DONE: begin
                    finish <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: self-checking bench for matmul_sequencer.
// A trace model built from the matrix loop structure predicts every output
// cycle of a job; a compare process checks the DUT against it each cycle.
// Expectations follow MATMUL_SEQ_AVGMAX_EN when it is defined for the build.

module tb_matmul_sequencer;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int INNER = 8;
    localparam int TOTAL = ROWS*INNER;
    localparam int ELEMS = ROWS*COLS;

`ifdef MATMUL_SEQ_AVGMAX_EN
    localparam int NOM_FINISH  = 194;
    localparam int GAP_FINISH  = 225;
    localparam int PULSE_EDGE  = 185;
    localparam int POST_PULSES = 16;
`else
    localparam int NOM_FINISH  = 177;
    localparam int GAP_FINISH  = 208;
    localparam int PULSE_EDGE  = 179;
    localparam int POST_PULSES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in;
    logic       valid_input;
    logic       x_load_en;
    logic [4:0] x_addr;
    logic [4:0] rom_addr;
    logic       mac_en;
    logic       mac_clr;
    logic       ram_we;
    logic       ram_re;
    logic [3:0] ram_addr;
    logic       post_en;
    logic       busy;
    logic       finish;

    typedef struct {
        int         edgeIdx;
        logic [7:0] flags;
        int         xa;
        int         ra;
        int         aa;
        bit         chkX;
        bit         chkR;
        bit         chkA;
    } exp_t;

    exp_t exp_q[$];
    bit   validPat[$];

    int vectors     = 0;
    int miscompares = 0;
    int curEdge     = 0;
    int loadCount, clrCount, weCount, postCount, finishCount, finishEdge;

    matmul_sequencer #(.ROWS(ROWS), .COLS(COLS), .INNER(INNER)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .valid_input(valid_input),
        .x_load_en  (x_load_en),
        .x_addr     (x_addr),
        .rom_addr   (rom_addr),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_addr   (ram_addr),
        .post_en    (post_en),
        .busy       (busy),
        .finish     (finish)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return {10'd0, x_load_en, x_addr, rom_addr, mac_en, mac_clr, ram_we,
                ram_re, ram_addr, post_en, busy, finish};
    endfunction

    task automatic pushExp(input int e, input bit xl, input bit me, input bit mc, input bit we,
                           input bit re, input bit pe, input bit bs, input bit fn,
                           input int xa, input int ra, input int aa);
        exp_t x;
        x.edgeIdx = e;
        x.flags   = {xl, me, mc, we, re, pe, bs, fn};
        x.xa      = xa;
        x.ra      = ra;
        x.aa      = aa;
        x.chkX    = xl | me;
        x.chkR    = me;
        x.chkA    = we | re;
        exp_q.push_back(x);
    endtask

    // Expected outputs after each edge of a job, edge 0 being the start edge.
    task automatic buildTrace();
        int e = 0;
        int n = 0;
        int i = 0;
        exp_q.delete();
        pushExp(e++, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        while (n < TOTAL) begin
            if (validPat[i]) begin
                pushExp(e++, 1, 0, 0, 0, 0, 0, 1, 0, n, 0, 0);
                n++;
            end else begin
                pushExp(e++, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            end
            i++;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int k = 0; k < INNER; k++) begin
                    pushExp(e++, 0, 1, k == 0, 0, 0, 0, 1, 0, r*INNER + k, c*INNER + k, 0);
                end
                pushExp(e++, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, r*COLS + c);
            end
        end
`ifdef MATMUL_SEQ_AVGMAX_EN
        for (int jj = 0; jj < ELEMS; jj++) begin
            pushExp(e++, 0, 0, 0, 0, 1, jj > 0, 1, 0, 0, 0, jj);
        end
        pushExp(e++, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
`endif
        pushExp(e++, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            pushExp(e++, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic makePattern(input bit gapped);
        int ones = 0;
        int i    = 0;
        bit b;
        validPat.delete();
        while (ones < TOTAL) begin
            b = gapped ? (i % 2 == 0) : 1'b1;
            validPat.push_back(b);
            if (b) ones++;
            i++;
        end
    endtask

    // Called at #1 after an edge: start is sampled on the next edge (edge 0).
    task automatic startJob();
        start_in = 1'b1;
        @(posedge clk);
        curEdge = 0;
        #1;
        start_in = 1'b0;
        buildTrace();
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n && i < validPat.size(); i++) begin
            valid_input = validPat[i];
            @(posedge clk);
            curEdge++;
            #1;
        end
        valid_input = 1'b0;
    endtask

    task automatic waitToEdge(input int n);
        while (curEdge < n) begin
            @(posedge clk);
            curEdge++;
            #1;
        end
    endtask

    task automatic drainAndCheck(input string tag, input int expFinish);
        for (int t = 0; t < 500 && exp_q.size() > 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checkOutput({tag, " drain timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        checkOutput({tag, " load pulses"},   loadCount,   TOTAL);
        checkOutput({tag, " mac_clr pulses"}, clrCount,   ELEMS);
        checkOutput({tag, " ram_we pulses"}, weCount,     ELEMS);
        checkOutput({tag, " post_en cycles"}, postCount,  POST_PULSES);
        checkOutput({tag, " finish pulses"}, finishCount, 1);
        checkOutput({tag, " finish edge"},   finishEdge,  expFinish);
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of the DUT against the predicted trace.
    task automatic compareLoop();
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.edgeIdx == 0) begin
                    loadCount   = 0;
                    clrCount    = 0;
                    weCount     = 0;
                    postCount   = 0;
                    finishCount = 0;
                    finishEdge  = -1;
                end
                got = {x_load_en, mac_en, mac_clr, ram_we, ram_re, post_en, busy, finish};
                checkOutput($sformatf("flags@%0d", e.edgeIdx), got, e.flags);
                if (e.chkX) checkOutput($sformatf("x_addr@%0d", e.edgeIdx), x_addr, e.xa);
                if (e.chkR) checkOutput($sformatf("rom_addr@%0d", e.edgeIdx), rom_addr, e.ra);
                if (e.chkA) checkOutput($sformatf("ram_addr@%0d", e.edgeIdx), ram_addr, e.aa);
                if (x_load_en) loadCount++;
                if (mac_clr)   clrCount++;
                if (ram_we)    weCount++;
                if (post_en)   postCount++;
                if (finish) begin
                    finishCount++;
                    finishEdge = e.edgeIdx;
                end
            end
        end
    endtask

    // Main sequence: reset, nominal job with stray inputs, abort, gapped job.
    initial begin
        rst         = 1'b0;
        start_in    = 1'b0;
        valid_input = 1'b0;
        fork
            compareLoop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", allOutputs(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle busy", busy, 0);

        $display("[TB] nominal job, continuous valid_input");
        makePattern(1'b0);
        startJob();
        applyStimulus(validPat.size());
        waitToEdge(49);
        start_in = 1'b1;
        waitToEdge(50);
        start_in = 1'b0;
        waitToEdge(132);
        checkOutput("elem23 first x_addr",   x_addr,   16);
        checkOutput("elem23 first rom_addr", rom_addr, 24);
        checkOutput("elem23 first mac_clr",  mac_clr,  1);
        waitToEdge(139);
        checkOutput("elem23 last x_addr",    x_addr,   23);
        checkOutput("elem23 last rom_addr",  rom_addr, 31);
        waitToEdge(140);
        checkOutput("elem23 ram_we",         ram_we,   1);
        checkOutput("elem23 ram_addr",       ram_addr, 11);
        waitToEdge(PULSE_EDGE - 1);
        valid_input = 1'b1;
        waitToEdge(PULSE_EDGE);
        valid_input = 1'b0;
        checkOutput("stray valid x_load_en", x_load_en, 0);
        drainAndCheck("nominal", NOM_FINISH);

        $display("[TB] abort during load");
        makePattern(1'b0);
        startJob();
        applyStimulus(10);
        checkOutput("abort pre x_addr", x_addr, 9);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("abort outputs", allOutputs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("after abort outputs", allOutputs(), 0);
        end

        $display("[TB] gapped load");
        makePattern(1'b1);
        checkOutput("gapped pattern length", validPat.size(), 63);
        startJob();
        applyStimulus(validPat.size());
        drainAndCheck("gapped", GAP_FINISH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
